// File: rtl/processor_trace_capture_pkg.sv
// Shared definitions for the processor trace receiver: FSM encodings,
// the default halt opcode and the field layout of a 40-bit trace entry.
package processor_trace_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HALTED  = 2'd2
  } trace_state_t;

  localparam logic [15:0] HALT_IR_DEFAULT = 16'h6000;

  localparam int PC_W    = 8;
  localparam int IR_W    = 16;
  localparam int ALU_W   = 16;
  localparam int ENTRY_W = PC_W + IR_W + ALU_W;

  // Entry layout, MSB first: {PC, IR, ALU}
  localparam int ALU_LSB = 0;
  localparam int IR_LSB  = ALU_LSB + ALU_W;
  localparam int PC_LSB  = IR_LSB + IR_W;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [PC_W-1:0]  pc,
    input logic [IR_W-1:0]  ir,
    input logic [ALU_W-1:0] alu
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[PC_LSB  +: PC_W]  = pc;
    e[IR_LSB  +: IR_W]  = ir;
    e[ALU_LSB +: ALU_W] = alu;
    return e;
  endfunction

endpackage

// File: rtl/processor_trace_capture_ring_buffer.sv
// Circular trace store with registered read port. When full, a write can
// either overwrite the oldest entry (OVERWRITE=1) or be dropped.
module trace_ring_buffer
  import processor_trace_capture_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int W         = ENTRY_W,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             rd_valid_reg;
  logic [W-1:0]     rd_data_reg;

  logic full;
  logic accept;
  logic do_read;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign accept  = wr_en && (!full || OVERWRITE);
  assign do_read = rd_en && (count_reg != '0);

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (accept && !clear) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b0;
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (full) begin
          // Write pointer has caught the read pointer: drop the oldest.
          rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
          overflow_reg <= 1'b1;
        end else begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end else if (do_read) begin
        rd_data_reg  <= mem[rd_ptr_reg];
        rd_valid_reg <= 1'b1;
        rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
        count_reg    <= count_reg - CNT_W'(1);
      end
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/processor_trace_capture.sv
// Trace receiver for the processor debug outputs: captures one entry per
// instruction change after Arm, freezes on the halt opcode, then plays back.
module processor_trace_capture
  import processor_trace_capture_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter logic [15:0] HALT_IR = HALT_IR_DEFAULT,
  parameter int          CYC_W   = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [15:0]            IR_In,
  input  logic [7:0]             PC_In,
  input  logic [15:0]            ALU_Out_In,
  input  logic                   Arm,
  input  logic                   Rd_Req,
  output logic                   Rd_Valid,
  output logic [39:0]            Rd_Data,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow,
  output logic                   Halted,
  output logic [CYC_W-1:0]       Cycles
);

  trace_state_t     state_reg, state_next;
  logic [15:0]      last_ir_reg, last_ir_next;
  logic [CYC_W-1:0] cycles_reg, cycles_next;

  logic buf_clear;
  logic buf_wr;
  logic buf_rd;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= ST_IDLE;
      last_ir_reg <= '0;
      cycles_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      last_ir_reg <= last_ir_next;
      cycles_reg  <= cycles_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_ir_next = last_ir_reg;
    cycles_next  = cycles_reg;
    buf_clear    = 1'b0;
    buf_wr       = 1'b0;
    buf_rd       = 1'b0;

    if (Arm) begin
      // Inverted seed guarantees the first sampled IR counts as a change.
      state_next   = ST_CAPTURE;
      last_ir_next = ~IR_In;
      cycles_next  = '0;
      buf_clear    = 1'b1;
    end else begin
      unique case (state_reg)
        ST_CAPTURE: begin
          if (cycles_reg != {CYC_W{1'b1}}) begin
            cycles_next = cycles_reg + CYC_W'(1);
          end
          if (IR_In != last_ir_reg) begin
            buf_wr       = 1'b1;
            last_ir_next = IR_In;
            if (IR_In == HALT_IR) begin
              state_next = ST_HALTED;
            end
          end
        end
        ST_HALTED: begin
          buf_rd = Rd_Req;
        end
        default: begin
        end
      endcase
    end
  end

  trace_ring_buffer #(
    .DEPTH     (DEPTH),
    .W         (ENTRY_W),
    .OVERWRITE (1'b1)
  ) u_ring (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (buf_clear),
    .wr_en    (buf_wr),
    .wr_data  (pack_entry(PC_In, IR_In, ALU_Out_In)),
    .rd_en    (buf_rd),
    .rd_valid (Rd_Valid),
    .rd_data  (Rd_Data),
    .count    (Count),
    .overflow (Overflow)
  );

  assign Halted = (state_reg == ST_HALTED);
  assign Cycles = cycles_reg;

endmodule
